// File: rtl/dram_sim_pkg.sv
// dram_sim_pkg: scheduler enums plus a compact AXI4 request/response struct pair
// used as the default channel types of the DRAM front-end scheduler.
package dram_sim_pkg;
  typedef enum logic {RD_PRIO, WR_DRAIN} sched_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_AR, GNT_AW} grant_e;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } axi_ar_t;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [5:0] atop; } axi_aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } axi_w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } axi_b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } axi_r_t;
  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } dram_req_t;
  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } dram_resp_t;
endpackage

// File: rtl/dram_sched_cnt.sv
// dram_sched_cnt: up/down outstanding-transaction counter, saturating at 0 and Max.
module dram_sched_cnt #(
  parameter int unsigned Max = 16,
  localparam int unsigned W = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign full_o = cnt_q == W'(Max);
  assign cnt_o  = cnt_q;
  assign cnt_d  = inc_i && !dec_i && !full_o ? cnt_q + 1'b1 :
                  dec_i && !inc_i && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= W'(Max));
`endif
endmodule

// File: rtl/axi_dram_rw_scheduler.sv
// axi_dram_rw_scheduler: gates AR/AW issue into the DRAM model (read priority, write
// drain, outstanding limits, one new address per cycle); W, R and B pass straight through.
module axi_dram_rw_scheduler import dram_sim_pkg::*; #(
  parameter int unsigned MaxReads   = 16,
  parameter int unsigned MaxWrites  = 16,
  parameter int unsigned WrHighMark = 8,
  parameter int unsigned WrLowMark  = 2,
  parameter type axi_req_t  = dram_req_t,
  parameter type axi_resp_t = dram_resp_t,
  localparam int unsigned RdW = $clog2(MaxReads + 1),
  localparam int unsigned WrW = $clog2(MaxWrites + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_req_t       slv_req_i,
  output axi_resp_t      slv_resp_o,
  output axi_req_t       mst_req_o,
  input  axi_resp_t      mst_resp_i,
  output logic [RdW-1:0] rd_inflight_o,
  output logic [WrW-1:0] wr_inflight_o,
  output logic           drain_o
);
  localparam int unsigned WrPW = WrW + 1;
  sched_state_e state_q, state_d;
  grant_e gnt, gnt_q, gnt_d;
  logic rr_rd_q, rr_rd_d, force_aw;
  logic [1:0] streak_q, streak_d;
  logic rd_full, wr_full, ar_elig, aw_elig, aw_rd, ar_hs, aw_hs, r_last_hs, b_hs;
  logic [WrPW-1:0] wr_pend;

  assign aw_rd   = slv_req_i.aw.atop[5];
  assign ar_elig = slv_req_i.ar_valid & ~rd_full;
  assign aw_elig = slv_req_i.aw_valid & ~wr_full & ~(aw_rd & rd_full);
  // after four back-to-back AR grants a competing AW wins once
  assign force_aw = rr_rd_q & (&streak_q);
  assign gnt = gnt_q != GNT_NONE ? gnt_q :
               state_q == WR_DRAIN ? (aw_elig ? GNT_AW : ar_elig ? GNT_AR : GNT_NONE) :
               ar_elig & ~(aw_elig & force_aw) ? GNT_AR : aw_elig ? GNT_AW : GNT_NONE;

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & (gnt == GNT_AR);
    mst_req_o.aw_valid  = slv_req_i.aw_valid & (gnt == GNT_AW);
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & (gnt == GNT_AR);
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & (gnt == GNT_AW);
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign wr_pend   = {1'b0, wr_inflight_o} + {{WrW{1'b0}}, slv_req_i.aw_valid};

  // a presented but unaccepted address keeps its grant until the handshake
  assign gnt_d = mst_req_o.ar_valid & ~mst_resp_i.ar_ready ? GNT_AR :
                 mst_req_o.aw_valid & ~mst_resp_i.aw_ready ? GNT_AW : GNT_NONE;
  assign rr_rd_d  = aw_hs ? 1'b0 : ar_hs | rr_rd_q;
  assign streak_d = aw_hs ? 2'd0 : !ar_hs ? streak_q : !rr_rd_q ? 2'd0 :
                    streak_q + {1'b0, ~&streak_q};
  assign state_d = state_q == RD_PRIO ?
                   (wr_pend >= WrPW'(WrHighMark) ? WR_DRAIN : RD_PRIO) :
                   (wr_inflight_o <= WrW'(WrLowMark) && !slv_req_i.aw_valid ? RD_PRIO : WR_DRAIN);
  assign drain_o = state_q == WR_DRAIN;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= RD_PRIO;
      gnt_q    <= GNT_NONE;
      rr_rd_q  <= 1'b0;
      streak_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_rd_q  <= rr_rd_d;
      streak_q <= streak_d;
    end

  // atomics with a read response also occupy a read slot
  dram_sched_cnt #(.Max(MaxReads)) i_rd_cnt (
    .clk_i, .rst_ni, .inc_i(ar_hs | (aw_hs & aw_rd)), .dec_i(r_last_hs),
    .cnt_o(rd_inflight_o), .full_o(rd_full)
  );
  dram_sched_cnt #(.Max(MaxWrites)) i_wr_cnt (
    .clk_i, .rst_ni, .inc_i(aw_hs), .dec_i(b_hs),
    .cnt_o(wr_inflight_o), .full_o(wr_full)
  );

`ifndef SYNTHESIS
  a_one_addr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mst_req_o.ar_valid && mst_req_o.aw_valid));
  a_ar_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_req_o.ar_valid && !mst_resp_i.ar_ready |=> mst_req_o.ar_valid);
  a_aw_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_req_o.aw_valid && !mst_resp_i.aw_ready |=> mst_req_o.aw_valid);
`endif
endmodule
